// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, opcode constants and the DataPath control bundle
// shared by the multi-cycle controller and its strobe decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MADDR = 4'd2,  S_LDACC = 4'd3,
        S_LDWB   = 4'd4,  S_SDACC  = 4'd5,  S_REXE  = 4'd6,  S_RWB   = 4'd7,
        S_BEQ    = 4'd8,  S_JMP    = 4'd9,  S_AEXE  = 4'd10, S_AWB   = 4'd11,
        S_HALT   = 4'd12, S_IRMEM  = 4'd13, S_IRIPR = 4'd14, S_TRAP  = 4'd15
    } state_t;

    localparam int OPC_R    = 0;
    localparam int OPC_LD   = 1;
    localparam int OPC_SD   = 2;
    localparam int OPC_BEQ  = 3;
    localparam int OPC_J    = 4;
    localparam int OPC_ADDI = 5;
    localparam int OPC_END  = 7;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_src;
        logic       ipr_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic is_blocking(state_t s);
        return s inside {S_FETCH, S_LDACC, S_SDACC};
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: Moore strobe decode of the current state; mem_ready only gates the
// strobes that must fire once per completed memory access.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0]        state_i,
    input  logic              mem_ready_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    state_t s;
    ctrl_t  c;

    assign s      = state_t'(state_i);
    assign ctrl_o = c;

    always_comb begin
        c               = '0;
        c.pc_write      = (s == S_FETCH && mem_ready_i) || s == S_JMP || s == S_IRIPR;
        c.pc_write_cond = s == S_BEQ;
        c.iord          = s inside {S_LDACC, S_SDACC};
        c.mem_read      = s inside {S_FETCH, S_MADDR, S_LDACC, S_REXE, S_AEXE};
        c.mem_write     = s == S_SDACC;
        c.ir_src        = s == S_IRIPR;
        c.ipr_write     = (s inside {S_LDACC, S_SDACC} && mem_ready_i) || s inside {S_RWB, S_AWB};
        c.ir_write      = s inside {S_IRMEM, S_IRIPR};
        c.mem_to_reg    = s == S_LDWB;
        c.alu_src_a     = s inside {S_MADDR, S_REXE, S_BEQ, S_AEXE};
        c.reg_write     = s inside {S_LDWB, S_RWB, S_AWB};
        c.reg_dst       = s == S_RWB;
        c.alu_op        = {s == S_REXE, s == S_BEQ};
        c.alu_src_b     = {s inside {S_DECODE, S_MADDR, S_AEXE}, s inside {S_DECODE, S_FETCH, S_IRIPR}};
        c.pc_source     = {s == S_JMP, s == S_BEQ};
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle controller with memory wait states, bounded wait timeout and TRAP/HALT status.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on undefined opcodes; otherwise they execute as R-type.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int                  OPCODE_W    = 3,
    parameter logic [OPCODE_W-1:0] OP_R        = OPCODE_W'(OPC_R),
    parameter logic [OPCODE_W-1:0] OP_LD       = OPCODE_W'(OPC_LD),
    parameter logic [OPCODE_W-1:0] OP_SD       = OPCODE_W'(OPC_SD),
    parameter logic [OPCODE_W-1:0] OP_BEQ      = OPCODE_W'(OPC_BEQ),
    parameter logic [OPCODE_W-1:0] OP_J        = OPCODE_W'(OPC_J),
    parameter logic [OPCODE_W-1:0] OP_ADDI     = OPCODE_W'(OPC_ADDI),
    parameter logic [OPCODE_W-1:0] OP_END      = OPCODE_W'(OPC_END),
    parameter int                  MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRSrc,
    output logic                IPRWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                ALUSrcA,
    output logic                RegWrite,
    output logic                RegDst,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic                halted,
    output logic                trap,
    output logic                retire,
    output logic [3:0]          state_o
);

    localparam int CNT_W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = S_REXE;
`endif

    state_t            state_q, state_d, dec_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              retire_q, retire_d, stalled;
    logic [CTRL_W-1:0] ctrl_raw;
    ctrl_t             ctrl;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_q   <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
        end
    end

    assign stalled = is_blocking(state_q) && !mem_ready;
    assign dec_d   = (opcode == OP_LD || opcode == OP_SD) ? S_MADDR :
                     opcode == OP_BEQ  ? S_BEQ  :
                     opcode == OP_J    ? S_JMP  :
                     opcode == OP_ADDI ? S_AEXE :
                     opcode == OP_END  ? S_HALT :
                     opcode == OP_R    ? S_REXE : ILLEGAL_NEXT;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:              state_d = mem_ready ? S_IRMEM : S_FETCH;
            S_IRMEM:              state_d = S_DECODE;
            S_DECODE:             state_d = dec_d;
            S_MADDR:              state_d = opcode == OP_LD ? S_LDACC : S_SDACC;
            S_LDACC:              state_d = mem_ready ? S_LDWB : S_LDACC;
            S_SDACC:              state_d = mem_ready ? S_IRIPR : S_SDACC;
            S_LDWB, S_RWB, S_AWB: state_d = S_IRIPR;
            S_REXE:               state_d = S_RWB;
            S_AEXE:               state_d = S_AWB;
            S_BEQ, S_JMP:         state_d = S_FETCH;
            S_IRIPR:              state_d = S_DECODE;
            default:              state_d = state_q;
        endcase
        // the last permitted stall cycle without mem_ready escalates to TRAP
        if (stalled && MEM_TIMEOUT != 0 && wait_q == CNT_W'(MEM_TIMEOUT - 1))
            state_d = S_TRAP;
        wait_d   = stalled ? wait_q + 1'b1 : '0;
        retire_d = state_d == S_IRIPR || state_q inside {S_BEQ, S_JMP};
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    assign ctrl        = reset ? '0 : ctrl_raw;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRSrc       = ctrl.ir_src;
    assign IPRWrite    = ctrl.ipr_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign halted      = !reset && state_q == S_HALT;
    assign trap        = !reset && state_q == S_TRAP;
    assign retire      = !reset && retire_q;
    assign state_o     = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: instruction-level model expands random programs into per-cycle expectations;
// a monitor pops them on the falling edge and compares state, strobes and status.
module tb_mc_ctrl_fsm;

    localparam int TMO = 15;
    localparam int PCW = 17, PCWC = 16, IORD = 15, MR = 14, MW = 13, IRS = 12;
    localparam int IPRW = 11, IRW = 10, M2R = 9, ASA = 8, RW = 7, RD = 6;

    typedef struct {
        int          st;
        logic [17:0] ctrl;
        logic [2:0]  status;
    } exp_t;

    logic        clock = 1'b0, reset = 1'b1, mem_ready = 1'b0;
    logic [2:0]  opcode = 3'd0, cur_op = 3'd0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRSrc, IPRWrite, IRWrite;
    logic        MemtoReg, ALUSrcA, RegWrite, RegDst, halted, trap, retire;
    logic [1:0]  ALUOp, ALUSrcB, PCSource;
    logic [3:0]  state_o;
    logic [17:0] ctrl_v;
    int          checks = 0, failures = 0;
    exp_t        sb[$];

    always #5 clock = ~clock;

    mc_ctrl_fsm dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRSrc(IRSrc), .IPRWrite(IPRWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .halted(halted), .trap(trap), .retire(retire), .state_o(state_o)
    );

    assign ctrl_v = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRSrc, IPRWrite, IRWrite,
                     MemtoReg, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};

    // strobes each state asserts, straight from the strobe table (m = mem_ready)
    function automatic logic [17:0] exp_ctrl(int s, logic m);
        logic [17:0] v;
        v = '0;
        case (s)
            0:  begin v[PCW] = m; v[MR] = 1; v[3:2] = 2'b01; end
            1:  v[3:2] = 2'b11;
            2:  begin v[MR] = 1; v[ASA] = 1; v[3:2] = 2'b10; end
            3:  begin v[IORD] = 1; v[MR] = 1; v[IPRW] = m; end
            4:  begin v[M2R] = 1; v[RW] = 1; end
            5:  begin v[IORD] = 1; v[MW] = 1; v[IPRW] = m; end
            6:  begin v[MR] = 1; v[ASA] = 1; v[5:4] = 2'b10; end
            7:  begin v[IPRW] = 1; v[RW] = 1; v[RD] = 1; end
            8:  begin v[PCWC] = 1; v[ASA] = 1; v[5:4] = 2'b01; v[1:0] = 2'b01; end
            9:  begin v[PCW] = 1; v[1:0] = 2'b10; end
            10: begin v[MR] = 1; v[ASA] = 1; v[3:2] = 2'b10; end
            11: begin v[IPRW] = 1; v[RW] = 1; end
            13: v[IRW] = 1;
            14: begin v[PCW] = 1; v[IRS] = 1; v[IRW] = 1; v[3:2] = 2'b01; end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, want);
        end
    endtask

    // one cycle: drive inputs and record what the DUT must present during it
    task automatic emit(input int s, input logic m, input logic r, input logic ret);
        exp_t e;
        @(posedge clock);
        #1;
        reset     = r;
        mem_ready = m;
        opcode    = cur_op;
        e.st      = r ? 0 : s;
        e.ctrl    = r ? 18'd0 : exp_ctrl(s, m);
        e.status  = r ? 3'd0 : {s == 12, s == 15, ret};
        sb.push_back(e);
    endtask

    // blocking memory access: nw stalled cycles then ready; res 0 done, 1 timed out, 2 reset
    task automatic access(input int s, input int nw, input logic ret0, input int rst_at, output int res);
        res = 0;
        for (int i = 0; i <= nw; i++) begin
            if (i == rst_at) begin
                emit(s, rb(), 1, 0);
                res = 2;
                return;
            end
            if (i == TMO) begin
                emit(15, rb(), 0, 0);
                res = 1;
                return;
            end
            emit(s, i == nw, 0, ret0 && i == 0);
        end
    endtask

    task automatic stop(input int res);
        if (res == 1) begin
            for (int i = 0; i < 4; i++) emit(15, rb(), 0, 0);
            emit(15, rb(), 1, 0);
        end
    endtask

    // start: 0 at FETCH, 1 at FETCH after a branch (retire), 2 at DECODE; next reports the same
    task automatic run_instr(input logic [2:0] op, input int start, input int fw, input int mw,
                             input int ra, output int next);
        int res;
        cur_op = op;
        next   = 0;
        if (start != 2) begin
            access(0, fw, start == 1, -1, res);
            if (res != 0) begin
                stop(res);
                return;
            end
            emit(13, rb(), 0, 0);
        end
        emit(1, rb(), 0, 0);
        case (op)
            3'd1, 3'd2: begin
                emit(2, rb(), 0, 0);
                access(op == 3'd1 ? 3 : 5, mw, 0, ra, res);
                if (res != 0) begin
                    stop(res);
                    return;
                end
                if (op == 3'd1) emit(4, rb(), 0, 0);
                emit(14, rb(), 0, 1);
                next = 2;
            end
            3'd3, 3'd4: begin
                emit(op == 3'd3 ? 8 : 9, rb(), 0, 0);
                next = 1;
            end
            3'd5: begin
                emit(10, rb(), 0, 0);
                emit(11, rb(), 0, 0);
                emit(14, rb(), 0, 1);
                next = 2;
            end
            3'd7: begin
                for (int i = 0; i < 20; i++) emit(12, rb(), 0, 0);
                emit(12, rb(), 1, 0);
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            3'd6: begin
                emit(15, rb(), 0, 0);
                stop(1);
            end
`endif
            default: begin
                emit(6, rb(), 0, 0);
                emit(7, rb(), 0, 0);
                emit(14, rb(), 0, 1);
                next = 2;
            end
        endcase
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        return r == 0 ? TMO + $urandom_range(0, 3) : r == 1 ? TMO - 1 : $urandom_range(0, 3);
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state", 32'(state_o), 32'(e.st));
            chk("strobes", 32'(ctrl_v), 32'(e.ctrl));
            chk("halted_trap_retire", 32'({halted, trap, retire}), 32'(e.status));
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int nx;
        logic [2:0] op;
        emit(0, 0, 1, 0);
        emit(0, 1, 1, 0);
        run_instr(3'd5, 0, 0, 0, -1, nx);      // ADDI, no waits
        run_instr(3'd1, nx, 0, 3, -1, nx);     // LD with 3 stall cycles
        run_instr(3'd4, nx, 0, 0, -1, nx);     // J back to FETCH
        run_instr(3'd0, nx, TMO, 0, -1, nx);   // fetch never ready
        run_instr(3'd7, nx, 1, 0, -1, nx);     // END -> HALT
        run_instr(3'd6, nx, 0, 0, -1, nx);     // undefined opcode
        run_instr(3'd2, nx, 2, 5, 2, nx);      // SD with reset mid-wait
        run_instr(3'd3, nx, TMO - 1, 0, -1, nx);
        run_instr(3'd1, nx, 0, TMO - 1, -1, nx);
        run_instr(3'd2, nx, 0, TMO, -1, nx);
        for (int k = 0; k < 300; k++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd5;
            run_instr(op, nx, pick_wait(), pick_wait(),
                      $urandom_range(0, 15) == 0 ? $urandom_range(0, 3) : -1, nx);
        end
        @(posedge clock);
        @(posedge clock);
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
